swap_regfile: RTL and testbench

- Register-file datapath driven directly by the swap FSM's `w` and `sel[1:0]` outputs.
- Holds 2^ADDR_W words plus one temp register.
- Latches the two swap addresses when a swap is requested, then performs the three-step exchange (tmp<=A, A<=B, B<=tmp) under FSM control.
- Also provides a host write port, a combinational read port, and a done pulse for the requesting logic.

---
 rtl/swap_regfile.sv | 102 ++++++++++
 tb/tb_swap_regfile.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/swap_regfile.sv
// swap_regfile: register file with FSM-driven three-step word swap,
// host write port, combinational read port and a done pulse.
// Optional protocol checker enabled by defining SWAP_CHECK_EN; without it
// err is tied low and no prev_sel register is built.
module swap_regfile #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              swap,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic              w,
  input  logic [1:0]        sel,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  localparam logic [1:0] SEL_IDLE = 2'd0;
  localparam logic [1:0] SEL_TMP  = 2'd1;
  localparam logic [1:0] SEL_B2A  = 2'd2;
  localparam logic [1:0] SEL_T2B  = 2'd3;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] tmp;
  logic [ADDR_W-1:0] a_q;
  logic [ADDR_W-1:0] b_q;

  assign rd_data = mem[rd_addr];
  assign busy    = w;

  // Capture swap addresses while idle, load tmp in step 1, flag completion.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_q  <= '0;
      b_q  <= '0;
      tmp  <= '0;
      done <= 1'b0;
    end else begin
      if (!w && (sel == SEL_IDLE) && swap) begin
        a_q <= addr_a;
        b_q <= addr_b;
      end
      if (w && (sel == SEL_TMP)) begin
        tmp <= mem[a_q];
      end
      done <= w && (sel == SEL_T2B);
    end
  end

  // Memory writes: swap steps own the array while w is high, host otherwise.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem <= '{default: '0};
    end else if (w) begin
      case (sel)
        SEL_B2A: mem[a_q] <= mem[b_q];
        SEL_T2B: mem[b_q] <= tmp;
        default: ;
      endcase
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

`ifdef SWAP_CHECK_EN
  logic [1:0] prev_sel;
  logic       viol_c;

  // Illegal strobe/step combinations or step transitions.
  always_comb begin
    viol_c = 1'b0;
    if (w && (sel == SEL_IDLE)) viol_c = 1'b1;
    if (!w && (sel != SEL_IDLE)) viol_c = 1'b1;
    if (!((sel == 2'(prev_sel + 2'd1)) ||
          ((prev_sel == SEL_IDLE) && (sel == SEL_IDLE)))) viol_c = 1'b1;
  end

  // Track previous step and hold err until reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_sel <= SEL_IDLE;
      err      <= 1'b0;
    end else begin
      prev_sel <= sel;
      if (viol_c) err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_swap_regfile.sv
// Testbench for swap_regfile: directed and random swaps against an array model.
module tb_swap_regfile;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       swap;
  logic [1:0] addr_a, addr_b;
  logic       w;
  logic [1:0] sel;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy, done, err;

  int passed = 0;
  int total  = 0;
  logic [7:0] model [4];

  swap_regfile #(.DATA_W(8), .ADDR_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .swap(swap), .addr_a(addr_a), .addr_b(addr_b),
    .w(w), .sel(sel), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic verify_all(input string tag);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      chk($sformatf("%s_mem%0d", tag, i), 32'(rd_data), 32'(model[i]));
    end
  endtask

  task automatic host_wr(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    model[a] = d;
  endtask

  // One full swap as the FSM would drive it; capture edge is T.
  task automatic do_swap(input string tag, input logic [1:0] a, input logic [1:0] b,
                         input bit chg, input bit bw, input logic [1:0] bwa,
                         input logic [7:0] bwd, input bit cw, input logic [7:0] cwd);
    logic [7:0] t;
    swap = 1'b1; addr_a = a; addr_b = b; sel = 2'd0; w = 1'b0;
    if (cw) begin wr_en = 1'b1; wr_addr = a; wr_data = cwd; model[a] = cwd; end
    tick();                                    // edge T
    swap = 1'b0; wr_en = 1'b0;
    chk({tag, "_done_T"}, 32'(done), 32'd0);
    if (chg) begin addr_a = 2'd0; addr_b = 2'd2; end
    if (bw) begin wr_en = 1'b1; wr_addr = bwa; wr_data = bwd; end
    for (int s = 1; s <= 3; s++) begin
      w = 1'b1; sel = 2'(s);
      #1;
      chk($sformatf("%s_busy%0d", tag, s), 32'(busy), 32'd1);
      tick();                                  // edges T+1..T+3
      if (s < 3) chk($sformatf("%s_done%0d", tag, s), 32'(done), 32'd0);
    end
    w = 1'b0; sel = 2'd0; wr_en = 1'b0;
    #1;
    chk({tag, "_done_T4"}, 32'(done), 32'd1);
    chk({tag, "_busy_T4"}, 32'(busy), 32'd0);
    t = model[a]; model[a] = model[b]; model[b] = t;
    verify_all(tag);
    tick();                                    // edge T+4
    chk({tag, "_done_T5"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; swap = 1'b0; addr_a = '0; addr_b = '0; w = 1'b0; sel = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    for (int i = 0; i < 4; i++) model[i] = 8'h00;
    tick(); tick();
    reset_n = 1'b1;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    verify_all("rst");

    // Basic 1<->3 swap
    host_wr(2'd0, 8'h11); host_wr(2'd1, 8'h22); host_wr(2'd2, 8'h33); host_wr(2'd3, 8'h44);
    verify_all("fill");
    do_swap("sw13", 2'd1, 2'd3, 0, 0, 2'd0, 8'h00, 0, 8'h00);

    // Same address: word unchanged
    do_swap("sw22", 2'd2, 2'd2, 0, 0, 2'd0, 8'h00, 0, 8'h00);

    // Host write during busy is dropped; while idle it lands
    do_swap("swbw", 2'd1, 2'd3, 0, 1, 2'd0, 8'hFF, 0, 8'h00);
    host_wr(2'd0, 8'hFF);
    verify_all("idlewr");

    // Address inputs changed after capture do not affect the swap
    do_swap("swchg", 2'd1, 2'd3, 1, 0, 2'd0, 8'h00, 0, 8'h00);

    // Host write in capture cycle feeds step 1
    do_swap("swcw", 2'd0, 2'd2, 0, 0, 2'd0, 8'h00, 1, 8'h5A);

    // Back-to-back: done pulse coincides with next capture
    swap = 1'b1; addr_a = 2'd0; addr_b = 2'd1;
    tick();
    swap = 1'b0;
    for (int s = 1; s <= 3; s++) begin w = 1'b1; sel = 2'(s); tick(); end
    w = 1'b0; sel = 2'd0;
    begin
      logic [7:0] t;
      t = model[0]; model[0] = model[1]; model[1] = t;
    end
    do_swap("b2b", 2'd2, 2'd3, 0, 0, 2'd0, 8'h00, 0, 8'h00);

    // Randomized swaps with host traffic
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 1)
        host_wr(2'($urandom_range(0, 3)), 8'($urandom));
      do_swap($sformatf("rnd%0d", it), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), 8'($urandom),
              bit'($urandom_range(0, 1)), 8'($urandom));
    end

    // Reset on edge T+2 aborts the swap
    swap = 1'b1; addr_a = 2'd1; addr_b = 2'd3;
    tick();
    swap = 1'b0; w = 1'b1; sel = 2'd1;
    tick();
    reset_n = 1'b0; w = 1'b0; sel = 2'd0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) model[i] = 8'h00;
    verify_all("abort");
    chk("abort_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("abort_done%0d", k), 32'(done), 32'd0);
      tick();
    end
    chk("abort_err", 32'(err), 32'd0);

`ifdef SWAP_CHECK_EN
    // Strobe without a step is a violation, sticky until reset
    w = 1'b1; sel = 2'd0;
    tick();
    w = 1'b0;
    chk("viol_err1", 32'(err), 32'd1);
    tick(); tick();
    chk("viol_err_hold", 32'(err), 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("viol_err_rst", 32'(err), 32'd0);
    // Skipped step 1 -> 2 from idle
    w = 1'b1; sel = 2'd2;
    tick();
    w = 1'b0; sel = 2'd0;
    chk("viol_skip", 32'(err), 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
